snd_mailbox: RTL and testbench



---
 rtl/snd_pkg.sv | 13 +
 rtl/snd_mailbox_mem.sv | 33 +++
 rtl/snd_mailbox.sv | 101 ++++++++++
 tb/tb_snd_mailbox.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/snd_pkg.sv
// Shared constants and parameter checks for the main-to-sound command mailbox.
// Latency: none (package). Backpressure: none (package).
package snd_pkg;

  localparam int OVF_DROP_NEW = 0;
  localparam int OVF_DROP_OLD = 1;

  // A legal depth is a power of two from 1 to 64.
  function automatic bit depth_ok(input int d);
    return (d >= 1) && (d <= 64) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/snd_mailbox_mem.sv
// Mailbox storage: dual-port array with a registered head-of-queue output.
// Latency: rd_data loads 1 cycle after rd_load. Backpressure: none, it writes whenever wr_en is high.
module snd_mailbox_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AW     = 2
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  input  logic              rd_load,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] head;

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // The entry being written this cycle may already be the next head.
  assign head = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)     rd_data <= '0;
    else if (rd_load) rd_data <= head;
  end

endmodule

// File: rtl/snd_mailbox.sv
// Main-to-sound command FIFO with NMI request, overflow flag and level readback.
// Latency: 1 cycle from push/pop to all outputs. Backpressure: none; a full FIFO drops new or oldest per OVERWRITE.
module snd_mailbox
  import snd_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int OVERWRITE = 0,
  parameter int REARM     = 1
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     nmi,
  input  logic                     int_ack,
  output logic                     overflow,
  input  logic                     ovf_clr
);

  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit OW_OLD = (OVERWRITE == OVF_DROP_OLD);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("snd_mailbox: DEPTH must be a power of two in 1..64");
  end

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  logic [AW-1:0] wptr, rptr, wptr_nxt, rptr_nxt;
  logic [LW-1:0] count_nxt;
  logic          pop_ok, full_hit, do_write, adv_r;
  logic          nmi_nxt, ovf_nxt;

  always_comb begin
    pop_ok   = rd_en && !empty;
    // Push against a full FIFO with no pop to make room.
    full_hit = wr_en && full && !pop_ok;
    do_write = wr_en && !(full_hit && !OW_OLD);
    adv_r    = pop_ok || (full_hit && OW_OLD);

    count_nxt = level;
    if (do_write && !full_hit && !pop_ok)  count_nxt = level + LW'(1);
    else if (pop_ok && !do_write)          count_nxt = level - LW'(1);

    wptr_nxt = do_write ? ptr_inc(wptr) : wptr;
    rptr_nxt = adv_r    ? ptr_inc(rptr) : rptr;

    nmi_nxt = nmi;
    if (do_write || ((REARM != 0) && pop_ok && (count_nxt != '0))) nmi_nxt = 1'b1;
    else if (int_ack)                                            nmi_nxt = 1'b0;

    ovf_nxt = overflow;
    if (full_hit)     ovf_nxt = 1'b1;
    else if (ovf_clr) ovf_nxt = 1'b0;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      nmi      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wptr     <= wptr_nxt;
      rptr     <= rptr_nxt;
      level    <= count_nxt;
      empty    <= (count_nxt == '0);
      full     <= (count_nxt == LW'(DEPTH));
      nmi      <= nmi_nxt;
      overflow <= ovf_nxt;
    end
  end

  snd_mailbox_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .wr_en   (do_write),
    .wr_addr (wptr),
    .wr_data (wr_data),
    .rd_addr (rptr_nxt),
    .rd_load (count_nxt != '0),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_snd_mailbox.sv
// Directed checks of snd_mailbox in drop-new, drop-old and single-entry latch configurations.
module tb_snd_mailbox;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       wr_en   [3];
  logic [7:0] wr_data [3];
  logic       rd_en   [3];
  logic       int_ack [3];
  logic       ovf_clr [3];
  logic [7:0] rd_data [3];
  logic       empty   [3];
  logic       full    [3];
  logic       nmi     [3];
  logic       overflow[3];
  logic [2:0] lvl_a, lvl_b;
  logic [0:0] lvl_c;

  int vectors = 0;
  int errors  = 0;

  always #5 clk_sys = ~clk_sys;

  snd_mailbox #(.DATA_W(8), .DEPTH(4), .OVERWRITE(0), .REARM(1)) u_dn (
    .clk_sys(clk_sys), .reset_n(reset_n), .wr_en(wr_en[0]), .wr_data(wr_data[0]),
    .rd_en(rd_en[0]), .rd_data(rd_data[0]), .empty(empty[0]), .full(full[0]),
    .level(lvl_a), .nmi(nmi[0]), .int_ack(int_ack[0]), .overflow(overflow[0]),
    .ovf_clr(ovf_clr[0]));

  snd_mailbox #(.DATA_W(8), .DEPTH(4), .OVERWRITE(1), .REARM(1)) u_do (
    .clk_sys(clk_sys), .reset_n(reset_n), .wr_en(wr_en[1]), .wr_data(wr_data[1]),
    .rd_en(rd_en[1]), .rd_data(rd_data[1]), .empty(empty[1]), .full(full[1]),
    .level(lvl_b), .nmi(nmi[1]), .int_ack(int_ack[1]), .overflow(overflow[1]),
    .ovf_clr(ovf_clr[1]));

  snd_mailbox #(.DATA_W(8), .DEPTH(1), .OVERWRITE(1), .REARM(1)) u_latch (
    .clk_sys(clk_sys), .reset_n(reset_n), .wr_en(wr_en[2]), .wr_data(wr_data[2]),
    .rd_en(rd_en[2]), .rd_data(rd_data[2]), .empty(empty[2]), .full(full[2]),
    .level(lvl_c), .nmi(nmi[2]), .int_ack(int_ack[2]), .overflow(overflow[2]),
    .ovf_clr(ovf_clr[2]));

  task automatic idle();
    for (int i = 0; i < 3; i++) begin
      wr_en[i] = 1'b0; rd_en[i] = 1'b0; int_ack[i] = 1'b0; ovf_clr[i] = 1'b0;
    end
  endtask

  // Strobes set before tick are sampled at the next rising edge; outputs are read 1 ns later.
  task automatic tick();
    @(posedge clk_sys);
    #1;
    idle();
  endtask

  task automatic push(input int k, input logic [7:0] v);
    wr_en[k] = 1'b1; wr_data[k] = v;
    tick();
  endtask

  task automatic pop(input int k);
    rd_en[k] = 1'b1;
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    idle();
    for (int i = 0; i < 3; i++) wr_data[i] = 8'h00;
    reset_n = 1'b0;
    #23;
    reset_n = 1'b1;
    tick();

    chk("rst_empty", 32'(empty[0]), 1);
    chk("rst_full", 32'(full[0]), 0);
    chk("rst_level", 32'(lvl_a), 0);
    chk("rst_nmi", 32'(nmi[0]), 0);
    chk("rst_ovf", 32'(overflow[0]), 0);
    chk("rst_rd", 32'(rd_data[0]), 0);

    push(0, 8'h11);
    chk("b_first_rd", 32'(rd_data[0]), 32'h11);
    push(0, 8'h22);
    chk("b_level", 32'(lvl_a), 2);
    chk("b_rd", 32'(rd_data[0]), 32'h11);
    chk("b_nmi", 32'(nmi[0]), 1);
    int_ack[0] = 1'b1; tick();
    chk("b_ack_nmi", 32'(nmi[0]), 0);
    pop(0);
    chk("b_pop1_rd", 32'(rd_data[0]), 32'h22);
    chk("b_rearm_nmi", 32'(nmi[0]), 1);
    pop(0);
    chk("b_pop2_empty", 32'(empty[0]), 1);
    chk("b_pop2_hold", 32'(rd_data[0]), 32'h22);
    chk("b_pop2_nmi", 32'(nmi[0]), 1);
    pop(0);
    chk("b_pop_empty_lvl", 32'(lvl_a), 0);
    chk("b_pop_empty_ovf", 32'(overflow[0]), 0);
    int_ack[0] = 1'b1; tick();

    for (int i = 1; i <= 5; i++) push(0, 8'(i));
    chk("dn_full", 32'(full[0]), 1);
    chk("dn_level", 32'(lvl_a), 4);
    chk("dn_ovf", 32'(overflow[0]), 1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("dn_rd%0d", i), 32'(rd_data[0]), 32'(i));
      pop(0);
    end
    chk("dn_drained", 32'(empty[0]), 1);
    ovf_clr[0] = 1'b1; tick();
    chk("dn_ovf_clr", 32'(overflow[0]), 0);

    for (int i = 0; i < 4; i++) push(0, 8'h31 + 8'(i));
    wr_en[0] = 1'b1; wr_data[0] = 8'h35; rd_en[0] = 1'b1; tick();
    chk("sim_full_lvl", 32'(lvl_a), 4);
    chk("sim_full_ovf", 32'(overflow[0]), 0);
    chk("sim_full_rd", 32'(rd_data[0]), 32'h32);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sim_drain%0d", i), 32'(rd_data[0]), 32'h32 + 32'(i));
      pop(0);
    end

    wr_en[0] = 1'b1; wr_data[0] = 8'h77; rd_en[0] = 1'b1; tick();
    chk("sim_empty_lvl", 32'(lvl_a), 1);
    chk("sim_empty_rd", 32'(rd_data[0]), 32'h77);
    pop(0);
    int_ack[0] = 1'b1; tick();
    chk("ack_pre_nmi", 32'(nmi[0]), 0);
    int_ack[0] = 1'b1; push(0, 8'h44);
    chk("ack_push_nmi", 32'(nmi[0]), 1);
    pop(0);

    for (int i = 0; i < 10; i++) begin
      push(0, 8'h80 + 8'(i));
      chk($sformatf("wrap_rd%0d", i), 32'(rd_data[0]), 32'h80 + 32'(i));
      pop(0);
      chk($sformatf("wrap_empty%0d", i), 32'(empty[0]), 1);
    end

    for (int i = 1; i <= 5; i++) push(1, 8'(i));
    chk("do_ovf", 32'(overflow[1]), 1);
    chk("do_level", 32'(lvl_b), 4);
    for (int i = 2; i <= 5; i++) begin
      chk($sformatf("do_rd%0d", i), 32'(rd_data[1]), 32'(i));
      pop(1);
    end
    chk("do_drained", 32'(empty[1]), 1);

    push(2, 8'hA5);
    chk("l_rd1", 32'(rd_data[2]), 32'hA5);
    chk("l_full", 32'(full[2]), 1);
    push(2, 8'h5A);
    chk("l_rd2", 32'(rd_data[2]), 32'h5A);
    chk("l_level", 32'(lvl_c), 1);
    chk("l_ovf", 32'(overflow[2]), 1);

    for (int i = 1; i <= 5; i++) push(0, 8'h60 + 8'(i));
    pop(0);
    chk("mr_pre_lvl", 32'(lvl_a), 3);
    chk("mr_pre_nmi", 32'(nmi[0]), 1);
    chk("mr_pre_ovf", 32'(overflow[0]), 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mr_lvl", 32'(lvl_a), 0);
    chk("mr_nmi", 32'(nmi[0]), 0);
    chk("mr_ovf", 32'(overflow[0]), 0);
    chk("mr_empty", 32'(empty[0]), 1);
    chk("mr_rd", 32'(rd_data[0]), 0);
    @(negedge clk_sys);
    reset_n = 1'b1;
    tick();
    push(0, 8'h99);
    chk("mr_post_lvl", 32'(lvl_a), 1);
    chk("mr_post_rd", 32'(rd_data[0]), 32'h99);
    chk("mr_post_nmi", 32'(nmi[0]), 1);
    chk("mr_post_ovf", 32'(overflow[0]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
